// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder: masked writes, extended reads, programmable wait states
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADRS   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_adrs,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      lane_q, lane_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [31:0]     req_off;
  logic            req_err;
  logic            accept;
  logic            enter_resp;
  logic            mem_we;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     load_data;
  logic [31:0]     wr_word;
  logic [3:0]      wr_be;

  assign req_ready = (state_q == IDLE) & reset;
  assign mem_busy  = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid & req_ready;

  // Request legality is decided once, at acceptance, from the live request.
  always_comb begin
    req_off = (req_adrs - BASE_ADRS) >> 2;
    req_err = 1'b0;
    if (req_adrs < BASE_ADRS) req_err = 1'b1;
    if (req_off >= 32'(DEPTH_WORDS)) req_err = 1'b1;
    case (req_funct3)
      3'b000, 3'b100: begin end
      3'b001, 3'b101: if (req_adrs[0]) req_err = 1'b1;
      3'b010:         if (req_adrs[1:0] != 2'b00) req_err = 1'b1;
      default:        req_err = 1'b1;
    endcase
    if (req_we && req_funct3[2]) req_err = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    lane_d   = lane_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          lane_d   = req_adrs[1:0];
          idx_d    = req_off[AW-1:0];
          wdata_d  = req_wdata;
          err_d    = req_err;
          wcnt_d   = 4'(WAIT_STATES);
          state_d  = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access operands come from the _d side so a zero-wait request is served on its acceptance edge.
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_comb begin
    rd_word = mem_q[idx_d];
    rd_byte = rd_word[{lane_d, 3'b000} +: 8];
    rd_half = lane_d[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3_d)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = rd_word;
    endcase
    case (funct3_d[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << lane_d;
        wr_word = {4{wdata_d[7:0]}};
      end
      2'b01: begin
        wr_be   = lane_d[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_d[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_word = wdata_d;
      end
    endcase
    mem_we      = enter_resp & we_d & ~err_d;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp) begin
      rsp_err_d   = err_d;
      rsp_rdata_d = (we_d | err_d) ? 32'h0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array is not reset, but a commit coinciding with reset low is dropped.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[idx_d][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       req_valid_v;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [31:0]      req_adrs;
  logic [31:0]      req_wdata;
  logic [2:0]       req_ready_v;
  logic [2:0]       rsp_valid_v;
  logic [2:0]       rsp_err_v;
  logic [2:0]       mem_busy_v;
  logic [2:0][31:0] rsp_rdata_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADRS(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_adrs(req_adrs), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rsp_rdata_v[0]), .rsp_err(rsp_err_v[0]), .mem_busy(mem_busy_v[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADRS(32'h100)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_adrs(req_adrs), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rsp_rdata_v[1]), .rsp_err(rsp_err_v[1]), .mem_busy(mem_busy_v[1]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADRS(32'h0)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
    .req_we(req_we), .req_funct3(req_funct3), .req_adrs(req_adrs), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[2]), .rsp_rdata(rsp_rdata_v[2]), .rsp_err(rsp_err_v[2]), .mem_busy(mem_busy_v[2]));

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] adrs;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] model_mem [DEPTH*4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 3 : 2;
  endfunction

  // Byte-addressed reference for the base-0 instances.
  function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] adrs,
                                       input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int unsigned size;
    logic        ok_f3;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ok_f3 = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    er    = !ok_f3 || (adrs % size != 0) || (adrs >= 32'(DEPTH*4));
    rd    = 32'h0;
    if (!er && we) begin
      for (int unsigned i = 0; i < size; i++) model_mem[adrs + i] = 8'(wdata >> (8*i));
    end
    if (!er && !we) begin
      v = 32'h0;
      for (int unsigned i = 0; i < size; i++) v = v | (32'(model_mem[adrs + i]) << (8*i));
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end
  endfunction

  task automatic do_req(input int sel, input logic we, input logic [2:0] f3, input logic [31:0] adrs,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_adrs = adrs; req_wdata = wdata;
    req_valid_v[sel] = 1'b1;
    guard = 0;
    while (!req_ready_v[sel] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid_v[sel] = 1'b0;
    req_adrs = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom); req_we = 1'($urandom);
    lat = 1;
    while (!rsp_valid_v[sel] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata_v[sel];
    err   = rsp_err_v[sel];
    @(negedge clk);
    check("strobe_one_cycle", {31'h0, rsp_valid_v[sel]}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat;
    int          acc_q[$];
    logic        compl_bad;
    logic        saw_rsp;

    for (int i = 0; i < DEPTH*4; i++) model_mem[i] = 8'h00;
    reset = 1'b0; req_valid_v = 3'b000;
    req_we = 1'b0; req_funct3 = 3'd0; req_adrs = 32'h0; req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_ready",     {29'h0, req_ready_v}, 32'h0);
    check("reset_busy",      {29'h0, mem_busy_v},  32'h0);
    check("reset_rsp_valid", {29'h0, rsp_valid_v}, 32'h0);
    check("reset_rsp_err",   {29'h0, rsp_err_v},   32'h0);
    check("reset_rdata",     rsp_rdata_v[0],       32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {29'h0, req_ready_v}, 32'h7);

    tbl.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h10, 32'h11223344, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 3'd0, 32'h13, 32'h000000AA, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hAA223344, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFAA, 1'b0});
    tbl.push_back('{1'b0, 3'd4, 32'h13, 32'h0,        32'h000000AA, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h12, 32'h0,        32'h0000AA22, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h12, 32'h0,        32'h00000022, 1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h10, 32'h0,        32'h00003344, 1'b0});
    tbl.push_back('{1'b1, 3'd2, 32'h14, 32'h5555CAFE, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 3'd1, 32'h16, 32'h00008001, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h16, 32'h0,        32'hFFFF8001, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h16, 32'h0,        32'h00008001, 1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h14, 32'h0,        32'h0000CAFE, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h17, 32'h0,        32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h12, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd1, 32'h11, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 3'd2, 32'(DEPTH*4), 32'h12345678, 32'h0,  1'b1});
    tbl.push_back('{1'b0, 3'd3, 32'h10, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h10, 32'h0,        32'hAA223344, 1'b0});

    foreach (tbl[i]) begin
      do_req(0, tbl[i].we, tbl[i].f3, tbl[i].adrs, tbl[i].wdata, rd, er, lat);
      model_access(tbl[i].we, tbl[i].f3, tbl[i].adrs, tbl[i].wdata, exp_rd, exp_er);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(ws_of(0) + 1));
    end

    for (int n = 0; n < 250; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] adrs, wdata;
      int          r;
      we = 1'($urandom); f3 = 3'($urandom); wdata = $urandom;
      r = $urandom_range(0, 9);
      if (r < 8)       adrs = $urandom_range(0, DEPTH*4 - 1);
      else if (r == 8) adrs = $urandom_range(DEPTH*4, DEPTH*4 + 16);
      else             adrs = $urandom;
      if (r < 4) adrs = adrs & 32'hFFFF_FFFC;
      if (r < 6 && f3 inside {3'd3, 3'd6, 3'd7}) f3 = 3'd2;
      model_access(we, f3, adrs, wdata, exp_rd, exp_er);
      do_req(0, we, f3, adrs, wdata, rd, er, lat);
      check($sformatf("rand%0d_rdata a=%h f3=%0d we=%0d", n, adrs, f3, we), rd, exp_rd);
      check($sformatf("rand%0d_err", n), {31'h0, er}, {31'h0, exp_er});
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(ws_of(0) + 1));
    end

    do_req(1, 1'b1, 3'd2, 32'h104, 32'hA5A5_0F0F, rd, er, lat);
    check("ws3_store_latency", 32'(lat), 32'd4);
    do_req(1, 1'b0, 3'd2, 32'h104, 32'h0, rd, er, lat);
    check("ws3_load_rdata", rd, 32'hA5A5_0F0F);
    do_req(1, 1'b0, 3'd2, 32'hFC, 32'h0, rd, er, lat);
    check("below_base_err", {31'h0, er}, 32'h1);
    check("below_base_rdata", rd, 32'h0);
    do_req(1, 1'b0, 3'd0, 32'h100 + 32'(DEPTH*4), 32'h0, rd, er, lat);
    check("past_end_err", {31'h0, er}, 32'h1);

    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'd2; req_adrs = 32'h100;
    req_valid_v[1] = 1'b1;
    compl_bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready_v[1] == mem_busy_v[1]) compl_bad = 1'b1;
      if (req_ready_v[1]) acc_q.push_back(n);
    end
    req_valid_v[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("ready_busy_complementary", {31'h0, compl_bad}, 32'h0);
    check("held_valid_accept_count", 32'(acc_q.size()), 32'd4);
    for (int i = 1; i < acc_q.size(); i++)
      check($sformatf("accept_spacing%0d", i), 32'(acc_q[i] - acc_q[i-1]), 32'd5);

    do_req(2, 1'b1, 3'd2, 32'h24, 32'hFFFFFFFF, rd, er, lat);
    check("ws2_latency", 32'(lat), 32'd3);
    do_req(2, 1'b0, 3'd2, 32'h24, 32'h0, rd, er, lat);
    check("ws2_load_rdata", rd, 32'hFFFFFFFF);

    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd2; req_adrs = 32'h20; req_wdata = 32'h12345678;
    req_valid_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_v[2] = 1'b0;
    saw_rsp = rsp_valid_v[2];
    @(negedge clk);
    saw_rsp |= rsp_valid_v[2];
    reset = 1'b0;
    @(negedge clk);
    saw_rsp |= rsp_valid_v[2];
    check("abort_ready_low", {31'h0, req_ready_v[2]}, 32'h0);
    check("abort_busy",      {31'h0, mem_busy_v[2]},  32'h0);
    check("abort_rdata",     rsp_rdata_v[2],          32'h0);
    check("abort_err",       {31'h0, rsp_err_v[2]},   32'h0);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      saw_rsp |= rsp_valid_v[2];
    end
    check("abort_no_rsp_valid", {31'h0, saw_rsp}, 32'h0);
    do_req(2, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
    check("abort_store_dropped", rd, 32'h0);
    do_req(2, 1'b0, 3'd2, 32'h24, 32'h0, rd, er, lat);
    check("abort_other_word_kept", rd, 32'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
